// File: rtl/tdm_demux_4x1_pkg.sv
// Shared definitions for the 4:1 TDM link (mux and demux sides).
// Holds the slot geometry, the FSM encoding and the lane write-mask decode.
package tdm_demux_4x1_pkg;

    localparam int SLOTS = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One-hot shadow write mask for lanes 0..2; lane 3 bypasses the shadow.
    function automatic logic [SLOTS-2:0] lane_wr_mask(input logic [SEL_W-1:0] sel);
        logic [SLOTS-2:0] mask;
        case (sel)
            2'd0:    mask = 3'b001;
            2'd1:    mask = 3'b010;
            2'd2:    mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: loads 1 on frame entry/resync, increments on each
// accepted beat, wraps 3->0. o_last flags the slot-3 position.
module tdm_slot_ctr
    import tdm_demux_4x1_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_adv,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_last
);

    logic [SEL_W-1:0] r_sel;

    // Slot counter register; load wins over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= SEL_W'(0);
        end else if (i_load) begin
            r_sel <= SEL_W'(1);
        end else if (i_adv) begin
            r_sel <= r_sel + SEL_W'(1);
        end else begin
            r_sel <= r_sel;
        end
    end

    assign o_sel  = r_sel;
    assign o_last = (r_sel == SEL_W'(SLOTS - 1));

endmodule

// File: rtl/tdm_demux_4x1.sv
// Receive side of the 4:1 TDM link: rebuilds 4-lane frames from a serial
// slot stream, aligning on start-of-frame markers and flagging misplaced ones.
module tdm_demux_4x1
    import tdm_demux_4x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_sof,
    output logic [SLOTS*WIDTH-1:0] o_out,
    output logic                   o_out_valid,
    output logic [SEL_W-1:0]       o_sel,
    output logic                   o_locked,
    output logic                   o_err
);

    state_t                       r_state;
    state_t                       w_nxt_state;
    logic                         w_load;
    logic                         w_adv;
    logic                         w_frame_done;
    logic                         w_err_hit;
    logic [SLOTS-2:0]             w_wr_en;
    logic [SEL_W-1:0]             w_sel;
    logic                         w_last;
    logic [(SLOTS-1)*WIDTH-1:0]   r_shadow;
    logic [SLOTS*WIDTH-1:0]       r_out;
    logic                         r_out_valid;
    logic                         r_err;

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .o_sel  (w_sel),
        .o_last (w_last)
    );

    // Next-state and per-beat control decode.
    always_comb begin
        w_nxt_state  = r_state;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        w_frame_done = 1'b0;
        w_err_hit    = 1'b0;
        w_wr_en      = {(SLOTS-1){1'b0}};
        case (r_state)
            ST_HUNT: begin
                if (i_valid && i_sof) begin
                    w_nxt_state = ST_RUN;
                    w_load      = 1'b1;
                    w_wr_en     = lane_wr_mask(SEL_W'(0));
                end else begin
                    w_nxt_state = ST_HUNT;
                end
            end
            ST_RUN: begin
                if (i_valid) begin
                    if (i_sof && (w_sel != SEL_W'(0))) begin
                        // Misplaced marker: drop the partial frame, restart at slot 0.
                        w_err_hit = 1'b1;
                        w_load    = 1'b1;
                        w_wr_en   = lane_wr_mask(SEL_W'(0));
                    end else begin
                        w_adv        = 1'b1;
                        w_frame_done = w_last;
                        w_wr_en      = lane_wr_mask(w_sel);
                    end
                end else begin
                    w_nxt_state = ST_RUN;
                end
            end
            default: begin
                w_nxt_state = ST_HUNT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Shadow lanes 0..2; kept across frames, not cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= {((SLOTS-1)*WIDTH){1'b0}};
        end else begin
            for (int k = 0; k < SLOTS - 1; k++) begin
                if (w_wr_en[k]) begin
                    r_shadow[k*WIDTH +: WIDTH] <= i_data;
                end else begin
                    r_shadow[k*WIDTH +: WIDTH] <= r_shadow[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Frame output and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= {(SLOTS*WIDTH){1'b0}};
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_out <= {i_data, r_shadow};
            end else begin
                r_out <= r_out;
            end
            r_out_valid <= w_frame_done;
            r_err       <= w_err_hit;
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_sel       = w_sel;
    assign o_locked    = (r_state == ST_RUN);
    assign o_err       = r_err;

endmodule

// File: tb/tb_tdm_demux_4x1.sv
// Directed bench for tdm_demux_4x1 (WIDTH=1) with a random frame phase
// driven from a simple transmit-mux model.
module tb_tdm_demux_4x1;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [0:0] i_data;
    logic       i_sof;
    logic [3:0] o_out;
    logic       o_out_valid;
    logic [1:0] o_sel;
    logic       o_locked;
    logic       o_err;

    int errors = 0;
    int checks = 0;

    tdm_demux_4x1 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_sof       (i_sof),
        .o_out       (o_out),
        .o_out_valid (o_out_valid),
        .o_sel       (o_sel),
        .o_locked    (o_locked),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of input; returns 1 time unit after the consuming edge.
    task automatic beat(input logic v, input logic sof, input logic d);
        @(negedge clk);
        i_valid = v;
        i_sof   = sof;
        i_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0] lanes;
    logic [3:0] last_out;
    logic       use_sof;

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out",    o_out,       32'h0);
        check("rst_ovalid", o_out_valid, 32'h0);
        check("rst_sel",    o_sel,       32'h0);
        check("rst_locked", o_locked,    32'h0);
        check("rst_err",    o_err,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hunting: beats without a marker are dropped.
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0, 1'b1);
            check("hunt_out",    o_out,       32'h0);
            check("hunt_ovalid", o_out_valid, 32'h0);
            check("hunt_locked", o_locked,    32'h0);
            check("hunt_sel",    o_sel,       32'h0);
        end

        // First frame 1,0,1,1 -> 4'b1101.
        beat(1'b1, 1'b1, 1'b1);
        check("f1_locked", o_locked, 32'h1);
        check("f1_sel1",   o_sel,    32'h1);
        beat(1'b1, 1'b0, 1'b0);
        check("f1_sel2",   o_sel,    32'h2);
        beat(1'b1, 1'b0, 1'b1);
        check("f1_sel3",   o_sel,    32'h3);
        check("f1_noval",  o_out_valid, 32'h0);
        beat(1'b1, 1'b0, 1'b1);
        check("f1_out",    o_out,       32'hD);
        check("f1_ovalid", o_out_valid, 32'h1);
        check("f1_sel0",   o_sel,       32'h0);
        check("f1_err",    o_err,       32'h0);
        idle();
        check("f1_pulse",  o_out_valid, 32'h0);
        check("f1_hold",   o_out,       32'hD);

        // Gapped frame 0,1,1,0 -> 4'b0110; sel frozen across gaps.
        beat(1'b1, 1'b1, 1'b0);
        idle();
        check("gap_sel1", o_sel, 32'h1);
        check("gap_nv1",  o_out_valid, 32'h0);
        beat(1'b1, 1'b0, 1'b1);
        idle();
        check("gap_sel2", o_sel, 32'h2);
        beat(1'b1, 1'b0, 1'b1);
        idle();
        idle();
        check("gap_sel3", o_sel, 32'h3);
        check("gap_nv3",  o_out_valid, 32'h0);
        check("gap_hold", o_out, 32'hD);
        beat(1'b1, 1'b0, 1'b0);
        check("gap_out",    o_out,       32'h6);
        check("gap_ovalid", o_out_valid, 32'h1);
        idle();
        check("gap_once", o_out_valid, 32'h0);

        // Misplaced marker at sel=2, then 0,1,0 -> 4'b0101.
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        check("rs_sel2", o_sel, 32'h2);
        beat(1'b1, 1'b1, 1'b1);
        check("rs_err",    o_err,       32'h1);
        check("rs_out",    o_out,       32'h6);
        check("rs_noval",  o_out_valid, 32'h0);
        check("rs_sel1",   o_sel,       32'h1);
        check("rs_locked", o_locked,    32'h1);
        beat(1'b1, 1'b0, 1'b0);
        check("rs_errclr", o_err, 32'h0);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        check("rs_out2",   o_out,       32'h5);
        check("rs_ovalid", o_out_valid, 32'h1);
        check("rs_err2",   o_err,       32'h0);

        // Async reset mid-frame at sel=2.
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        check("ar_sel2", o_sel, 32'h2);
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out",    o_out,       32'h0);
        check("ar_sel",    o_sel,       32'h0);
        check("ar_locked", o_locked,    32'h0);
        check("ar_ovalid", o_out_valid, 32'h0);
        check("ar_err",    o_err,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        check("ar_hunt_locked", o_locked, 32'h0);
        check("ar_hunt_sel",    o_sel,    32'h0);
        check("ar_hunt_out",    o_out,    32'h0);

        // Random frames from a transmit-mux model with random gaps.
        for (int f = 0; f < 100; f++) begin
            lanes   = 4'($urandom_range(0, 15));
            use_sof = (f == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int s = 0; s < 4; s++) begin
                repeat ($urandom_range(0, 2))
                    beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                beat(1'b1, (s == 0) ? use_sof : 1'b0, lanes[s]);
                check("rnd_err", o_err, 32'h0);
            end
            check("rnd_out",    o_out,       {28'h0, lanes});
            check("rnd_ovalid", o_out_valid, 32'h1);
            last_out = lanes;
        end
        idle();
        check("rnd_final_hold", o_out,       {28'h0, last_out});
        check("rnd_final_nv",   o_out_valid, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
